priority_arbiter_4req: RTL and testbench
========================================

// Module: priority_arbiter_4req
// PURPOSE
//  Shares one downstream resource between four requesters, req[3]..req[0].
//  Arbitrates with the same I3>I2>I1>I0 ordering our 4-to-2 priority encoding uses.
//  Locks a grant until the owner finishes, drops its request, or overstays its limit.
//  Sits in front of any shared datapath slot; gnt_id/gnt_vld feed downstream muxes like Y1:Y0/V.
// PARAMETERS
//  MAX_HOLD  16  max consecutive cycles one grant may be held; 0 = unlimited (no timeout)
//  CNT_W     5   hold-counter width; must satisfy MAX_HOLD < 2**CNT_W
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  rst_n    in   1      reset, asynchronous assert, active-low
//  req      in   4      request vector; req[i]=1 -> requester i wants resource
//  done     in   1      current owner finished; sampled only in GRANT
//  gnt      out  4      one-hot grant, registered; 0000 when idle
//  gnt_id   out  2      binary index of granted requester (3->11 ... 0->00)
//  gnt_vld  out  1      1 when gnt is nonzero (equals |gnt)
//  timeout  out  1      1-cycle pulse: grant revoked by MAX_HOLD expiry
// BEHAVIOUR
//  Reset (rst_n=0, async): gnt=0000, gnt_id=00, gnt_vld=0, timeout=0, state=IDLE, cnt=0, last_id=00.
//  All outputs registered; no combinational path from req/done to outputs.
//  FSM with 2 states:
//   IDLE : if req!=0 -> pick winner, load gnt/gnt_id, gnt_vld=1, cnt=0, last_id=winner, go GRANT.
//          if req==0 -> stay; gnt=0. done ignored in IDLE.
//          Latency: req asserted at edge N is seen as gnt at edge N+1.
//   GRANT: release when any holds: done=1 | req[gnt_id]=0 | (MAX_HOLD!=0 & cnt==MAX_HOLD-1).
//          Release -> next edge gnt=0000, gnt_vld=0, gnt_id keeps last value, go IDLE.
//          No release -> cnt+=1, grant held unchanged; new higher-priority req never preempts.
//  Each grant is followed by at least 1 idle cycle (gnt=0) before the next grant.
//  With MAX_HOLD!=0, a grant lasts at most MAX_HOLD cycles.
//  timeout=1 for exactly the first IDLE cycle after an expiry release.
//  If done=1 or req drop coincides with expiry -> normal release, timeout stays 0.
//  cnt saturates and is unused when MAX_HOLD=0; it cannot wrap within a legal grant.
//  Async reset mid-GRANT: gnt drops immediately (not at the clock edge); no timeout pulse.
//  Winner selection is combinational from req and last_id; only one bit of gnt is ever set.
// CONFIGURATION
//  ROUND_ROBIN_EN defined  : rotating priority. Search order is last_id-1, last_id-2, ...,
//                            last_id (mod 4), so the last winner has lowest priority.
//                            With reset last_id=00, the first search order is 3,2,1,0.
//  ROUND_ROBIN_EN undefined: fixed priority 3>2>1>0 every arbitration.
//                            last_id is still tracked but not used for selection.
// TESTING
//  1 rst_n=0, req=1111, clk running -> gnt=0000, gnt_id=00, gnt_vld=0, timeout=0 throughout.
//  2 req=0110 from IDLE -> next edge gnt=0100, gnt_id=10.
//    Then pulse done -> gnt=0000 for 1 cycle, then gnt=0010, gnt_id=01.
//  3 req=1111 held, done pulsed every grant cycle:
//    ROUND_ROBIN_EN gives gnt_id 3,2,1,0,3; fixed build gives 3,3,3,3.
//  4 MAX_HOLD=16, req=1000 held, no done -> gnt=1000 for 16 cycles, then gnt=0000 with timeout=1
//    for 1 cycle, then gnt=1000 again.
//  5 gnt=0001 held, req 0001->0000 at cycle 3 -> gnt=0000 next edge, timeout=0.
//    Also: done=1 on the expiry cycle -> timeout=0.
//  6 rst_n pulled low mid-GRANT, off clock edge -> gnt=0000 at once.
//    After release, req=0001 gives gnt on the 2nd edge after rst_n rises.

Source files
------------

// File: rtl/priority_arbiter_4req.sv
// Four-requester arbiter with grant lock, hold-time limit and a mandatory idle gap between grants.
// Define ROUND_ROBIN_EN for rotating priority; the default build uses fixed priority 3>2>1>0.
//
// state | meaning
// IDLE  | no owner; arbitrate on req each edge
// GRANT | one requester owns the resource; hold counter runs
module priority_arbiter_4req #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    state_t           state_nxt;
    logic             run;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       last_id;
    logic [1:0]       last_id_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       gnt_id_nxt;
    logic             gnt_vld_nxt;
    logic             timeout_nxt;
    logic [1:0]       win_id;
    logic             win_vld;
    logic [1:0]       idx;
    logic             owner_req;
    logic             expired;
    logic             release_g;

`ifdef ROUND_ROBIN_EN
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        win_vld = 1'b0;
        win_id  = last_id;
        idx     = last_id;
        for (int k = 4; k >= 1; k--) begin
            idx = last_id - 2'(k);
            if (req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end
`else
    always_comb begin
        idx     = last_id;
        win_vld = |req;
        if (req[3])      win_id = 2'd3;
        else if (req[2]) win_id = 2'd2;
        else if (req[1]) win_id = 2'd1;
        else             win_id = 2'd0;
    end
`endif

    assign owner_req = req[gnt_id];
    assign expired   = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign release_g = done || !owner_req || expired;

    // run holds arbitration off for the first edge after reset release,
    // so a fresh grant never races the deassertion of rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run     <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            last_id <= 2'd0;
            gnt     <= 4'd0;
            gnt_id  <= 2'd0;
            gnt_vld <= 1'b0;
            timeout <= 1'b0;
        end else begin
            run     <= 1'b1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last_id <= last_id_nxt;
            gnt     <= gnt_nxt;
            gnt_id  <= gnt_id_nxt;
            gnt_vld <= gnt_vld_nxt;
            timeout <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run && win_vld) state_nxt = GRANT;
            GRANT:   if (release_g)      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        gnt_vld_nxt = gnt_vld;
        timeout_nxt = 1'b0;
        cnt_nxt     = cnt;
        last_id_nxt = last_id;
        case (state)
            IDLE: begin
                if (run && win_vld) begin
                    gnt_nxt     = 4'(4'b0001 << win_id);
                    gnt_id_nxt  = win_id;
                    gnt_vld_nxt = 1'b1;
                    cnt_nxt     = '0;
                    last_id_nxt = win_id;
                end else begin
                    gnt_nxt     = 4'd0;
                    gnt_vld_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (release_g) begin
                    gnt_nxt     = 4'd0;
                    gnt_vld_nxt = 1'b0;
                    // A cooperative release on the expiry cycle is not a timeout.
                    timeout_nxt = expired && !done && owner_req;
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                gnt_nxt     = 4'd0;
                gnt_vld_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_priority_arbiter_4req.sv
// Directed bench for priority_arbiter_4req with an expectation queue checked on the falling edge.
// Expected values for the arbitration-order test depend on whether ROUND_ROBIN_EN is defined.
module tb_priority_arbiter_4req;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] id;
        logic       to;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    exp_t exp_q[$];
    int   compared;
    int   mismatched;

    priority_arbiter_4req #(.MAX_HOLD(16), .CNT_W(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [3:0] g, input logic [1:0] id, input logic to);
        exp_t e;
        e.g  = g;
        e.id = id;
        e.to = to;
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        logic [7:0] obs;
        logic [7:0] want;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL %s: no expectation queued", tag);
        end else begin
            e    = exp_q.pop_front();
            obs  = {gnt, gnt_id, gnt_vld, timeout};
            want = {e.g, e.id, |e.g, e.to};
            assert (obs === want) else begin
                mismatched++;
                $error("FAIL %s: gnt/id/vld/to observed %b/%b/%b/%b expected %b/%b/%b/%b",
                       tag, gnt, gnt_id, gnt_vld, timeout, e.g, e.id, |e.g, e.to);
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] g,
                        input logic [1:0] id, input logic to, input string tag);
        req  = r;
        done = d;
        push(g, id, to);
        @(negedge clk);
        check(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        #1;
        push(4'd0, 2'd0, 1'b0);
        check("rst_async");
        for (int i = 0; i < 3; i++) begin
            push(4'd0, 2'd0, 1'b0);
            @(negedge clk);
            check("rst_hold");
        end
        rst_n = 1'b1;
        step(4'b0000, 1'b0, 4'd0, 2'd0, 1'b0, "rst_exit");
    endtask

    logic [3:0] t3_g[9];
    logic [1:0] t3_id[9];

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        req        = 4'b1111;
        done       = 1'b0;
`ifdef ROUND_ROBIN_EN
        t3_g  = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 4'b1000};
        t3_id = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd3};
`else
        t3_g  = '{4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 4'b1000};
        t3_id = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        @(negedge clk);
        do_reset();

        // Basic grant, done release, idle gap, next requester.
        step(4'b0110, 1'b0, 4'b0100, 2'd2, 1'b0, "t2_grant");
        step(4'b0110, 1'b1, 4'b0000, 2'd2, 1'b0, "t2_done");
        step(4'b0010, 1'b0, 4'b0010, 2'd1, 1'b0, "t2_next");
        step(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, "t2_drop");

        // Arbitration order with all requesters active and done every grant cycle.
        do_reset();
        for (int i = 0; i < 9; i++)
            step(4'b1111, 1'b1, t3_g[i], t3_id[i], 1'b0, "t3_order");
        step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, "t3_drop");

        // Hold limit expiry and timeout pulse.
        do_reset();
        for (int i = 0; i < 16; i++)
            step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "t4_hold");
        step(4'b1000, 1'b0, 4'b0000, 2'd3, 1'b1, "t4_expire");
        step(4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0, "t4_regrant");
        step(4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, "t4_drop");

        // Request drop mid-grant, then done coinciding with expiry.
        for (int i = 0; i < 3; i++)
            step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t5_hold");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t5_drop");
        for (int i = 0; i < 16; i++)
            step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t5_long");
        step(4'b0001, 1'b1, 4'b0000, 2'd0, 1'b0, "t5_done_exp");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t5_no_pulse");

        // Asynchronous reset while a grant is held.
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t6_grant");
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t6_hold");
        #2;
        rst_n = 1'b0;
        push(4'd0, 2'd0, 1'b0);
        #1;
        check("t6_async");
        push(4'd0, 2'd0, 1'b0);
        @(negedge clk);
        check("t6_in_rst");
        rst_n = 1'b1;
        step(4'b0001, 1'b0, 4'b0000, 2'd0, 1'b0, "t6_edge1");
        step(4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0, "t6_edge2");
        step(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, "t6_drop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
